// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, FSM encoding and output masks for pipe_ctrl.
// Optional performance counters in the top are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  localparam int N_STG      = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_BUSY = 2'd2
  } state_e;

  function automatic logic [N_STG-1:0] stage_bit(input int s);
    return N_STG'(1) << s;
  endfunction

  // Each event holds the stages upstream of the blockage and zero-fills the next one down.
  localparam logic [N_STG-1:0] MEM_STALL  = stage_bit(STG_PC) | stage_bit(STG_IF_ID) |
                                            stage_bit(STG_ID_EX) | stage_bit(STG_EX_MEM);
  localparam logic [N_STG-1:0] MEM_BUBBLE = stage_bit(STG_MEM_WB);
  localparam logic [N_STG-1:0] MDU_STALL  = stage_bit(STG_PC) | stage_bit(STG_IF_ID) |
                                            stage_bit(STG_ID_EX);
  localparam logic [N_STG-1:0] MDU_BUBBLE = stage_bit(STG_EX_MEM);
  localparam logic [N_STG-1:0] FLUSH_BUBBLE = stage_bit(STG_IF_ID) | stage_bit(STG_ID_EX);
  localparam logic [N_STG-1:0] LU_STALL   = stage_bit(STG_PC) | stage_bit(STG_IF_ID);
  localparam logic [N_STG-1:0] LU_BUBBLE  = stage_bit(STG_ID_EX);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare: the ID instruction reads a register the EX load has not produced yet.
// Purely combinational; r0 is never a hazard.
module hazard_detect (
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = id_use_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit     = id_use_rt_i && (id_rt_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: memory wait > MDU busy > branch flush > load-use.
// Define PIPE_CTRL_PERF_EN to add saturating stall_cycles/flush_count outputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [N_STG-1:0] stall,
  output logic [N_STG-1:0] bubble,
  output logic             mdu_busy,
  output state_e           dbg_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mem_wait;
  logic             mdu_active;
  logic             flush;

  hazard_detect u_hazard (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_use_rs_i   (id_use_rs),
    .id_use_rt_i   (id_use_rt),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .load_use_o    (load_use)
  );

  assign mem_wait = mem_req && !mem_ack;
  // The ack cycle of a wait that interrupted a multi-cycle op is already an MDU cycle again.
  assign mdu_active = (state_q == ST_MDU_BUSY) ||
                      ((state_q == ST_MEM_WAIT) && (cnt_q != '0));
  assign dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = '0;
    bubble   = '0;
    mdu_busy = 1'b0;
    flush    = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_wait) begin
      stall   = MEM_STALL;
      bubble  = MEM_BUBBLE;
      state_d = ST_MEM_WAIT;
    end else if (mdu_active) begin
      stall    = MDU_STALL;
      bubble   = MDU_BUBBLE;
      mdu_busy = 1'b1;
      cnt_d    = cnt_q - CNT_W'(1);
      state_d  = (cnt_q == CNT_W'(1)) ? ST_RUN : ST_MDU_BUSY;
    end else if (ex_mdu_start) begin
      stall    = MDU_STALL;
      bubble   = MDU_BUBBLE;
      mdu_busy = 1'b1;
      cnt_d    = CNT_W'(MDU_LAT - 1);
      state_d  = ST_MDU_BUSY;
    end else begin
      state_d = ST_RUN;
      if (ex_branch_taken) begin
        bubble = FLUSH_BUBBLE;
        flush  = 1'b1;
      end else if (load_use) begin
        stall  = LU_STALL;
        bubble = LU_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if ((stall != '0) && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush && (flush_count_q != '1))          flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle priority model feeds an expected queue
// checked every cycle, plus literal checks of the documented hazard scenarios.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic       mem_req, mem_ack;
  logic [4:0] stall, bubble;
  logic       mdu_busy;
  state_e     dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;
  int          m_left = 0;
  int          nb, nh;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pipe_ctrl #(.MDU_LAT(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .stall           (stall),
    .bubble          (bubble),
    .mdu_busy        (mdu_busy),
    .dbg_state       (dbg_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  // ---------------- check helpers ----------------
  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model: priority rules, remaining MDU hold cycles as a plain count ----------------
  always @(negedge clk) begin
    logic [4:0] es, eb;
    logic       ebz, lu;
    es  = 5'b0;
    eb  = 5'b0;
    ebz = 1'b0;
    lu  = ex_mem_read && (ex_rd != 5'd0) &&
          ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (rst) begin
      m_left = 0;
    end else if (mem_req && !mem_ack) begin
      es = 5'b01111; eb = 5'b10000;
    end else if (m_left > 0) begin
      es = 5'b00111; eb = 5'b01000; ebz = 1'b1;
      m_left--;
    end else if (ex_mdu_start) begin
      es = 5'b00111; eb = 5'b01000; ebz = 1'b1;
      m_left = LAT - 1;
    end else if (ex_branch_taken) begin
      eb = 5'b00110;
    end else if (lu) begin
      es = 5'b00011; eb = 5'b00100;
    end
    exp_q.push_back({es, eb, ebz});
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no expected entry");
    end else begin
      exp_e = exp_q.pop_front();
      chk5("sb_stall",  stall,    exp_e[10:6]);
      chk5("sb_bubble", bubble,   exp_e[5:1]);
      chk1("sb_busy",   mdu_busy, exp_e[0]);
      chki("sb_no_overlap", int'(stall & bubble), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_in();
    rst = 1'b1; ex_mdu_start = 1'b1; mem_req = 1'b1; ex_branch_taken = 1'b1;
    look();
    chk5("rst_stall", stall, 5'b0);
    chk5("rst_bubble", bubble, 5'b0);
    chk1("rst_busy", mdu_busy, 1'b0);
    adv(); look();
    chk5("rst_stall2", stall, 5'b0);
    chk1("rst_state", dbg_state == ST_RUN, 1'b1);
    adv(); clear_in(); look();
    chk5("idle_stall", stall, 5'b0);

    // load-use on rs, then released next cycle
    adv(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; look();
    chk5("lu_stall", stall, 5'b00011);
    chk5("lu_bubble", bubble, 5'b00100);
    adv(); clear_in(); look();
    chk5("lu_after_stall", stall, 5'b0);
    chk5("lu_after_bubble", bubble, 5'b0);
    // load-use on rt only
    adv(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; look();
    chk5("lu_rt_stall", stall, 5'b00011);
    // matching register not actually read
    adv(); clear_in(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9; look();
    chk5("lu_unused_stall", stall, 5'b0);
    // r0 destination
    adv(); clear_in(); ex_mem_read = 1'b1; id_use_rs = 1'b1; look();
    chk5("lu_r0_stall", stall, 5'b0);
    // not a load
    adv(); clear_in(); ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; look();
    chk5("lu_noload_stall", stall, 5'b0);
    // branch flush beats load-use
    adv(); clear_in(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    ex_branch_taken = 1'b1; look();
    chk5("br_lu_bubble", bubble, 5'b00110);
    chk5("br_lu_stall", stall, 5'b0);

    // single MDU op: held exactly LAT cycles, branch inside is ignored
    adv(); clear_in(); ex_mdu_start = 1'b1; look();
    chk5("mdu_stall", stall, 5'b00111);
    chk5("mdu_bubble", bubble, 5'b01000);
    nb = mdu_busy ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      adv(); clear_in();
      if (i == 2) ex_branch_taken = 1'b1;
      look();
      if (i == 2) begin
        chk5("mdu_br_bubble", bubble, 5'b01000);
        chk1("mdu_state", dbg_state == ST_MDU_BUSY, 1'b1);
      end
      if (mdu_busy) nb++;
    end
    chki("mdu_busy_cycles", nb, LAT);

    // memory wait of 3 cycles, then ack with request
    for (int i = 0; i < 3; i++) begin
      adv(); clear_in(); mem_req = 1'b1; look();
      chk5("mw_stall", stall, 5'b01111);
      chk5("mw_bubble", bubble, 5'b10000);
    end
    adv(); mem_req = 1'b1; mem_ack = 1'b1; look();
    chk5("mw_ack_stall", stall, 5'b0);
    adv(); clear_in(); look();
    chk5("mw_done_bubble", bubble, 5'b0);
    adv(); mem_req = 1'b1; mem_ack = 1'b1; look();
    chk5("mw_fast_ack_stall", stall, 5'b0);
    // memory wait beats an MDU start, which is dropped
    adv(); clear_in(); mem_req = 1'b1; ex_mdu_start = 1'b1; look();
    chk5("mw_mdu_stall", stall, 5'b01111);
    adv(); clear_in(); look();
    chk1("mw_mdu_dropped", mdu_busy, 1'b0);

    // 2-cycle memory wait arriving in MDU cycle 3: EX held LAT+2 cycles
    nb = 0; nh = 0;
    for (int c = 1; c <= 16; c++) begin
      adv(); clear_in();
      if (c == 1) ex_mdu_start = 1'b1;
      if (c == 3 || c == 4) mem_req = 1'b1;
      if (c == 5) begin mem_req = 1'b1; mem_ack = 1'b1; end
      look();
      if (stall[2]) nh++;
      if (mdu_busy) nb++;
    end
    chki("mdu_mw_hold", nh, LAT + 2);
    chki("mdu_mw_busy", nb, LAT);

    // reset in MDU cycle 2 abandons the op; a fresh start works normally
    adv(); clear_in(); ex_mdu_start = 1'b1; look();
    chk1("rst_mdu_busy1", mdu_busy, 1'b1);
    adv(); clear_in(); rst = 1'b1; ex_branch_taken = 1'b1; look();
    chk5("rst_mdu_stall", stall, 5'b0);
    chk5("rst_mdu_bubble", bubble, 5'b0);
    adv(); clear_in(); look();
    chk1("post_rst_busy", mdu_busy, 1'b0);
    chk5("post_rst_stall", stall, 5'b0);
    nb = 0;
    for (int c = 1; c <= 12; c++) begin
      adv(); clear_in();
      if (c == 1) ex_mdu_start = 1'b1;
      look();
      if (mdu_busy) nb++;
    end
    chki("restart_busy_cycles", nb, LAT);

    adv(); clear_in(); look();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
